apb_slave: RTL
==============

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 16: address and data bus width.
REQ-002 SHALL have parameter NUM_REGS, default 8: register count, index range 0..NUM_REGS-1, minimum 2.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1: ACCESS cycles with pready low before completion, range 0..15.
REQ-004 SHALL have parameter ID_VALUE, default 16'hA5B0: read-only contents of register 0.
REQ-005 SHALL have port pclk, input, 1 bit: peripheral clock, all state updates on the rising edge.
REQ-006 SHALL have port preset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port pselect, input, 1 bit: slave select from the bridge.
REQ-008 SHALL have port penable, input, 1 bit: access-phase strobe.
REQ-009 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port paddr, input, WIDTH bits: register index, unscaled.
REQ-011 SHALL have port pwdata, input, WIDTH bits: write data.
REQ-012 SHALL have port prdata, output reg, WIDTH bits: read data.
REQ-013 SHALL have port pready, output reg, 1 bit: transfer complete.
REQ-014 SHALL have port pslverr, output reg, 1 bit: error response, valid only while pready=1.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, READY; all outputs registered.
REQ-016 IDLE: on an edge sampling pselect=1, penable=0, SHALL latch paddr, pwrite and pwdata; go to READY if WAIT_CYCLES=0, else load counter with WAIT_CYCLES and go to WAIT.
REQ-017 IDLE: any other input combination SHALL leave the state in IDLE.
REQ-018 WAIT: on each edge sampling pselect=1, penable=1, SHALL decrement the counter; at count 1 SHALL go to READY.
REQ-019 Entry into READY SHALL set pready=1 in the same edge, so pready is high in ACCESS cycle WAIT_CYCLES+1.
REQ-020 READY SHALL last exactly one cycle; the next edge SHALL clear pready, pslverr and prdata and return to IDLE.
REQ-021 Back-to-back: an edge sampled in IDLE immediately after READY SHALL accept a new SETUP with no extra bubble.
REQ-022 Decode SHALL occur on latched values: index valid iff paddr < NUM_REGS, comparison at full WIDTH.
REQ-023 Error SHALL be flagged for an invalid index, or for a write to index 0; pslverr=1 together with pready=1.
REQ-024 Valid write SHALL commit the latched pwdata into the register on the edge leaving READY, and only if pselect=1 and penable=1 at that edge.
REQ-025 Errored writes SHALL not modify any register.
REQ-026 Valid read SHALL drive prdata with the register value on entry into READY; index 0 reads ID_VALUE.
REQ-027 Errored reads SHALL return prdata=0.
REQ-028 prdata SHALL be 0 whenever pready=0.
REQ-029 Bus inputs changing during WAIT or READY SHALL be ignored; latched values govern the transfer.
REQ-030 Abort: pselect=0 sampled in WAIT or READY SHALL return to IDLE, clear outputs and commit no write.
REQ-031 penable=0 with pselect=1 sampled in WAIT is a protocol violation; SHALL restart as a new SETUP by re-latching inputs and reloading the counter.

Reset
REQ-032 preset_n=0 SHALL immediately, independent of pclk, force state IDLE, counter 0, pready=0, pslverr=0, prdata=0, and registers 1..NUM_REGS-1 to 0.
REQ-033 Reset asserted mid-transfer SHALL drop that transfer with no write committed.
REQ-034 The first SETUP SHALL be accepted on the first edge after release of preset_n.

Verification
REQ-035 Write 16'h1234 to index 3, then read index 3 (WAIT_CYCLES=1) -> pready high in 2nd ACCESS cycle of each transfer, pslverr=0, prdata=16'h1234.
REQ-036 Read index 0, then write 16'hFFFF to index 0 -> read returns 16'hA5B0; write gets pslverr=1 and a re-read still returns 16'hA5B0.
REQ-037 Read index 8 and write index 16'h00FF (NUM_REGS=8) -> pslverr=1 with pready, prdata=0, registers 1..7 unchanged.
REQ-038 WAIT_CYCLES=0, two back-to-back writes to indices 1 and 2 -> pready high in first ACCESS cycle of each, both values read back.
REQ-039 Deassert pselect in WAIT of a write to index 5 -> FSM returns to IDLE, pready never asserts, index 5 reads 0.
REQ-040 Pulse preset_n low during WAIT of a write to index 2 holding 16'h00AA -> outputs 0 immediately, index 2 reads 0 after reset.

Source files
------------

// File: rtl/apb_slave.sv
// APB register slave: ID register at index 0 plus NUM_REGS-1 read/write registers, with configurable wait states.
// Latency: pready rises WAIT_CYCLES+1 ACCESS cycles after SETUP, and a write commits on the edge that completes it.
// Backpressure: pready is held low for WAIT_CYCLES ACCESS cycles; dropping pselect aborts the transfer.
module apb_slave #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 8,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [WIDTH-1:0] ID_VALUE    = 'hA5B0
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             pselect,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr
);

  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam logic [WIDTH-1:0] NUM_REGS_W = WIDTH'(NUM_REGS);
  localparam logic [3:0]       WAIT_LOAD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             write_q;

  // Index 0 storage is never written; reads of index 0 return ID_VALUE.
  logic [WIDTH-1:0] regs [NUM_REGS];

  logic [WIDTH-1:0] dec_addr;
  logic             dec_write;
  logic             dec_valid;
  logic             dec_err;
  logic [WIDTH-1:0] dec_rdata;
  logic             commit;

  // Decode the transfer about to complete: live bus in IDLE (zero-wait case), latched copy otherwise.
  always_comb begin
    dec_addr  = (state == ST_IDLE) ? paddr  : addr_q;
    dec_write = (state == ST_IDLE) ? pwrite : write_q;
    dec_valid = (dec_addr < NUM_REGS_W);
    dec_err   = !dec_valid || (dec_write && (dec_addr == '0));
    dec_rdata = '0;
    if (dec_valid && !dec_write) begin
      if (dec_addr == '0) begin
        dec_rdata = ID_VALUE;
      end else begin
        dec_rdata = regs[dec_addr[IDX_W-1:0]];
      end
    end
  end

  // A write lands only when leaving READY with the bus still in ACCESS and no error flagged.
  assign commit = (state == ST_READY) && write_q && !pslverr && pselect && penable;

  // Transfer FSM: latch SETUP, count wait states, present a one-cycle registered response.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pselect && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            if (WAIT_CYCLES == 0) begin
              state   <= ST_READY;
              pready  <= 1'b1;
              pslverr <= dec_err;
              prdata  <= dec_rdata;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!pselect) begin
            // Bridge abandoned the transfer.
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (!penable) begin
            // SETUP seen again mid-wait: treat it as a fresh transfer.
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            cnt     <= WAIT_LOAD;
          end else if (cnt == 4'd1) begin
            cnt     <= '0;
            state   <= ST_READY;
            pready  <= 1'b1;
            pslverr <= dec_err;
            prdata  <= dec_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_READY: begin
          state   <= ST_IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
      endcase
    end
  end

  // Register file update on a committed write.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

endmodule
